dma_copy_engine: RTL and testbench
==================================

// Module: dma_copy_engine
// PURPOSE
//  Word-granular memory-to-memory copy engine on the data-memory port (addr/write_data/memread/memwrite/sign_mask/read_data).
//  Acts as the initiator on that port; data_mem is the responder. Muxed onto the port in place of the CPU load/store path while busy.
//  Software loads src/dst/length and pulses start; the engine copies len_words 32-bit words and pulses done.
// PARAMETERS
//  LEN_W      12   width of word-count input/counter (max 2^LEN_W-1 words per transfer)
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      1-cycle pulse; latches src_addr/dst_addr/len_words when idle
//  abort        in   1      synchronous cancel of an active transfer
//  src_addr     in   32     source byte address; bits[1:0] ignored (treated as 0)
//  dst_addr     in   32     destination byte address; bits[1:0] ignored
//  len_words    in   LEN_W  number of words to copy
//  busy         out  1      high from the cycle after accepted start until the cycle after done
//  done         out  1      1-cycle pulse on completion
//  remaining    out  LEN_W  words not yet written
//  mem_stall    in   1      responder stall; freezes engine while high
//  addr         out  32     memory byte address
//  write_data   out  32     store data
//  memread      out  1      load strobe
//  memwrite     out  1      store strobe
//  sign_mask    out  4      access type; always 4'b0111 (word, unsigned) when a strobe is high, else 4'b0000
//  read_data    in   32     load data; valid the cycle after memread was sampled
// BEHAVIOUR
//  Reset: state IDLE; busy, done, memread, memwrite = 0; addr, write_data = 0; sign_mask = 0; remaining = 0.
//  All outputs registered. States: IDLE, RD, WAIT, WR, FIN.
//  IDLE: start=1 with len_words!=0 -> latch src/dst ({addr[31:2],2'b00}), remaining=len_words, go RD.
//   start=1 with len_words==0 -> go FIN (no memory access). start with busy=1 ignored.
//  RD (1 cycle): memread=1, addr=src_ptr, sign_mask=4'b0111 -> WAIT.
//  WAIT (1 cycle): strobes low; capture read_data into data_reg at end of cycle -> WR.
//  WR (1 cycle): memwrite=1, addr=dst_ptr, write_data=data_reg, sign_mask=4'b0111; at edge src_ptr+=4, dst_ptr+=4, remaining-=1;
//   remaining was 1 -> FIN, else -> RD.
//  FIN (1 cycle): done=1, busy=0 next cycle -> IDLE. Throughput: 3 cycles/word; latency = 3*N+2 cycles from start to done.
//  Pointers wrap modulo 2^32 (0xFFFF_FFFC + 4 -> 0x0000_0000); no fault raised.
//  mem_stall=1: state, pointers, remaining, data_reg and all outputs held; WAIT capture deferred until mem_stall=0.
//  abort=1 in RD/WAIT/WR: access on the port that cycle completes; next state IDLE, strobes low, done NOT pulsed,
//   remaining keeps value (words left). abort beats mem_stall. abort in IDLE/FIN: no effect.
//  Overlapping src/dst regions: copy proceeds strictly ascending; result undefined-by-design if dst>src and overlapping.
//  Reset mid-transfer: immediate return to reset values; in-flight store may or may not land.
// CONFIGURATION
//  DMA_FILL_EN defined: adds ports fill_mode (in,1) and fill_value (in,32), latched at start. fill_mode=1 skips RD/WAIT:
//   WR loop writes fill_value to dst_ptr, 1 cycle/word, src ignored. fill_mode=0 behaves as plain copy.
//  DMA_FILL_EN undefined: ports absent; copy only.
// TESTING
//  Copy 4 words src=0x1000 dst=0x1100, mem=11,22,33,44 -> dst holds 11,22,33,44; done at cycle 14; remaining=0.
//  start with len_words=0 -> no memread/memwrite ever; done 1 cycle after FIN entry; busy high exactly 1 cycle.
//  src=0x1003 dst=0x1102 len=1 -> accesses at 0x1000 and 0x1100; sign_mask=4'b0111 on both strobes.
//  mem_stall high 5 cycles during WAIT of word 2 of 3 -> outputs frozen; data correct; done delayed by exactly 5 cycles.
//  abort asserted in WR of word 2 of 4 -> word 2 written, word 3 never read; done never pulses; remaining=2.
//  DMA_FILL_EN, fill_mode=1, fill_value=0xDEADBEEF, len=3 -> three consecutive stores, no memread; done after 5 cycles.

Source files
------------

// File: rtl/dma_copy_engine.sv
// Word-granular memory-to-memory copy engine driving the data-memory port.
// Optional fill mode (constant-pattern store loop) is enabled by defining DMA_FILL_EN.
module dma_copy_engine #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] remaining,
    input  logic             mem_stall,
    output logic [31:0]      addr,
    output logic [31:0]      write_data,
    output logic             memread,
    output logic             memwrite,
    output logic [3:0]       sign_mask,
    input  logic [31:0]      read_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [3:0]  WORD_MASK  = 4'b0111;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [2:0]       state, state_n;
    logic [31:0]      src_ptr, src_ptr_n;
    logic [31:0]      dst_ptr, dst_ptr_n;
    logic [LEN_W-1:0] remaining_n;
    logic             busy_n, done_n;
    logic [31:0]      addr_n, write_data_n;
    logic             memread_n, memwrite_n;
    logic [3:0]       sign_mask_n;

    logic             start_fill;
    logic [31:0]      start_fill_value;
    logic             fill_active;
    logic [31:0]      fill_data;
    logic             active;

`ifdef DMA_FILL_EN
    logic        fill_reg;
    logic [31:0] fill_value_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_reg       <= 1'b0;
            fill_value_reg <= 32'h0;
        end else if (state == S_IDLE && start) begin
            fill_reg       <= fill_mode;
            fill_value_reg <= fill_value;
        end
    end

    assign start_fill       = fill_mode;
    assign start_fill_value = fill_value;
    assign fill_active      = fill_reg;
    assign fill_data        = fill_value_reg;
`else
    assign start_fill       = 1'b0;
    assign start_fill_value = 32'h0;
    assign fill_active      = 1'b0;
    assign fill_data        = 32'h0;
`endif

    assign active = (state == S_RD) || (state == S_WAIT) || (state == S_WR);

    // Next-state and next-output logic; every port output is a register loaded from here.
    always_comb begin
        state_n      = state;
        src_ptr_n    = src_ptr;
        dst_ptr_n    = dst_ptr;
        remaining_n  = remaining;
        busy_n       = busy;
        done_n       = 1'b0;
        addr_n       = addr;
        write_data_n = write_data;
        memread_n    = 1'b0;
        memwrite_n   = 1'b0;
        sign_mask_n  = 4'b0000;

        if (active && abort) begin
            // The store issued this cycle still counts as a copied word.
            state_n = S_IDLE;
            busy_n  = 1'b0;
            if (state == S_WR) begin
                src_ptr_n   = src_ptr + 32'd4;
                dst_ptr_n   = dst_ptr + 32'd4;
                remaining_n = remaining - LEN_W'(1);
            end
        end else if (active && mem_stall) begin
            memread_n   = memread;
            memwrite_n  = memwrite;
            sign_mask_n = sign_mask;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy_n = 1'b1;
                        if (len_words != '0) begin
                            src_ptr_n   = src_addr & ALIGN_MASK;
                            dst_ptr_n   = dst_addr & ALIGN_MASK;
                            remaining_n = len_words;
                            sign_mask_n = WORD_MASK;
                            if (start_fill) begin
                                state_n      = S_WR;
                                memwrite_n   = 1'b1;
                                addr_n       = dst_addr & ALIGN_MASK;
                                write_data_n = start_fill_value;
                            end else begin
                                state_n   = S_RD;
                                memread_n = 1'b1;
                                addr_n    = src_addr & ALIGN_MASK;
                            end
                        end else begin
                            state_n = S_FIN;
                        end
                    end
                end
                S_RD: begin
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    state_n      = S_WR;
                    write_data_n = read_data;
                    memwrite_n   = 1'b1;
                    addr_n       = dst_ptr;
                    sign_mask_n  = WORD_MASK;
                end
                S_WR: begin
                    src_ptr_n   = src_ptr + 32'd4;
                    dst_ptr_n   = dst_ptr + 32'd4;
                    remaining_n = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_n = S_FIN;
                    end else if (fill_active) begin
                        state_n      = S_WR;
                        memwrite_n   = 1'b1;
                        addr_n       = dst_ptr + 32'd4;
                        write_data_n = fill_data;
                        sign_mask_n  = WORD_MASK;
                    end else begin
                        state_n     = S_RD;
                        memread_n   = 1'b1;
                        addr_n      = src_ptr + 32'd4;
                        sign_mask_n = WORD_MASK;
                    end
                end
                S_FIN: begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
                default: begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            src_ptr    <= 32'h0;
            dst_ptr    <= 32'h0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr       <= 32'h0;
            write_data <= 32'h0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            sign_mask  <= 4'b0000;
        end else begin
            state      <= state_n;
            src_ptr    <= src_ptr_n;
            dst_ptr    <= dst_ptr_n;
            remaining  <= remaining_n;
            busy       <= busy_n;
            done       <= done_n;
            addr       <= addr_n;
            write_data <= write_data_n;
            memread    <= memread_n;
            memwrite   <= memwrite_n;
            sign_mask  <= sign_mask_n;
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed self-checking bench for dma_copy_engine with a word-addressed memory model.
// Fill-mode vectors are compiled in only when DMA_FILL_EN is defined.
module tb_dma_copy_engine;

    localparam int LEN_W = 12;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len_words;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] remaining;
    logic             mem_stall;
    logic [31:0]      addr;
    logic [31:0]      write_data;
    logic             memread;
    logic             memwrite;
    logic [3:0]       sign_mask;
    logic [31:0]      read_data;
`ifdef DMA_FILL_EN
    logic             fill_mode;
    logic [31:0]      fill_value;
`endif

    logic [31:0] mem [0:4095];
    int          rd_count;
    int          wr_count;
    logic [31:0] last_rd_addr;
    logic [31:0] last_wr_addr;
    logic [3:0]  last_rd_mask;
    logic [3:0]  last_wr_mask;
    int          bad_mask;

    int total;
    int bad;

    int          done_cyc;
    int          busy_cyc;
    int          rd_base;
    int          wr_base;
    logic [31:0] frz_addr;
    logic        frz_memread;
    logic        frz_memwrite;
    logic [LEN_W-1:0] frz_rem;

    dma_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
`ifdef DMA_FILL_EN
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .mem_stall  (mem_stall),
        .addr       (addr),
        .write_data (write_data),
        .memread    (memread),
        .memwrite   (memwrite),
        .sign_mask  (sign_mask),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: read data appears the cycle after the load strobe is accepted.
    always @(posedge clk) begin
        if (memread && !mem_stall) begin
            read_data    <= mem[addr[13:2]];
            rd_count     <= rd_count + 1;
            last_rd_addr <= addr;
            last_rd_mask <= sign_mask;
        end
        if (memwrite && !mem_stall) begin
            mem[addr[13:2]] <= write_data;
            wr_count        <= wr_count + 1;
            last_wr_addr    <= addr;
            last_wr_mask    <= sign_mask;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if ((memread || memwrite) && sign_mask != 4'b0111) bad_mask <= bad_mask + 1;
            if (!memread && !memwrite && sign_mask != 4'b0000) bad_mask <= bad_mask + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Pulses start, then watches each cycle (cycle 1 = first after start) until done or budget.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len,
                                 input int stall_at, input int stall_len, input int abort_at,
                                 input int budget);
        int cyc;
        @(negedge clk);
        src_addr  = src;
        dst_addr  = dst;
        len_words = LEN_W'(len);
        start     = 1'b1;
        rd_base   = rd_count;
        wr_base   = wr_count;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        done_cyc = 0;
        busy_cyc = 0;
        while (cyc <= budget) begin
            if (busy) busy_cyc++;
            if (stall_len > 0 && cyc == stall_at) mem_stall = 1'b1;
            if (stall_len > 0 && cyc == stall_at + stall_len) mem_stall = 1'b0;
            if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
                frz_addr     = addr;
                frz_memread  = memread;
                frz_memwrite = memwrite;
                frz_rem      = remaining;
            end
            abort = (abort_at > 0 && cyc == abort_at);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        abort     = 1'b0;
        mem_stall = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rd_count  = 0;
        wr_count  = 0;
        bad_mask  = 0;
        read_data = 32'h0;
        last_rd_addr = 32'h0;
        last_wr_addr = 32'h0;
        last_rd_mask = 4'h0;
        last_wr_mask = 4'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h400] = 32'h0000_0011;
        mem[12'h401] = 32'h0000_0022;
        mem[12'h402] = 32'h0000_0033;
        mem[12'h403] = 32'h0000_0044;
        start     = 1'b0;
        abort     = 1'b0;
        mem_stall = 1'b0;
        src_addr  = 32'h0;
        dst_addr  = 32'h0;
        len_words = '0;
`ifdef DMA_FILL_EN
        fill_mode  = 1'b0;
        fill_value = 32'h0;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_memread", {31'h0, memread}, 32'h0);
        checkOutput("rst_memwrite", {31'h0, memwrite}, 32'h0);
        checkOutput("rst_addr", addr, 32'h0);
        checkOutput("rst_wdata", write_data, 32'h0);
        checkOutput("rst_mask", {28'h0, sign_mask}, 32'h0);
        checkOutput("rst_remaining", {20'h0, remaining}, 32'h0);

        $display("[TB] copy 4 words 0x1000 -> 0x1100");
        applyStimulus(32'h1000, 32'h1100, 4, 0, 0, 0, 40);
        checkOutput("copy4_done_cycle", done_cyc, 14);
        checkOutput("copy4_remaining", {20'h0, remaining}, 32'h0);
        checkOutput("copy4_d0", mem[12'h440], 32'h0000_0011);
        checkOutput("copy4_d1", mem[12'h441], 32'h0000_0022);
        checkOutput("copy4_d2", mem[12'h442], 32'h0000_0033);
        checkOutput("copy4_d3", mem[12'h443], 32'h0000_0044);
        checkOutput("copy4_reads", rd_count - rd_base, 4);
        checkOutput("copy4_writes", wr_count - wr_base, 4);
        @(negedge clk);
        checkOutput("copy4_busy_after", {31'h0, busy}, 32'h0);

        $display("[TB] zero-length start");
        applyStimulus(32'h1000, 32'h1100, 0, 0, 0, 0, 20);
        checkOutput("zero_done_cycle", done_cyc, 2);
        checkOutput("zero_busy_cycles", busy_cyc, 1);
        checkOutput("zero_reads", rd_count - rd_base, 0);
        checkOutput("zero_writes", wr_count - wr_base, 0);

        $display("[TB] unaligned addresses");
        applyStimulus(32'h1003, 32'h1102, 1, 0, 0, 0, 20);
        checkOutput("unal_done_cycle", done_cyc, 5);
        checkOutput("unal_rd_addr", last_rd_addr, 32'h1000);
        checkOutput("unal_wr_addr", last_wr_addr, 32'h1100);
        checkOutput("unal_rd_mask", {28'h0, last_rd_mask}, 32'h7);
        checkOutput("unal_wr_mask", {28'h0, last_wr_mask}, 32'h7);

        $display("[TB] stall 5 cycles in WAIT of word 2");
        applyStimulus(32'h1000, 32'h1200, 3, 5, 5, 0, 50);
        checkOutput("stall_done_cycle", done_cyc, 16);
        checkOutput("stall_frz_addr", frz_addr, 32'h1004);
        checkOutput("stall_frz_memread", {31'h0, frz_memread}, 32'h0);
        checkOutput("stall_frz_memwrite", {31'h0, frz_memwrite}, 32'h0);
        checkOutput("stall_frz_rem", {20'h0, frz_rem}, 32'h2);
        checkOutput("stall_d0", mem[12'h480], 32'h0000_0011);
        checkOutput("stall_d1", mem[12'h481], 32'h0000_0022);
        checkOutput("stall_d2", mem[12'h482], 32'h0000_0033);

        $display("[TB] abort in WR of word 2");
        applyStimulus(32'h1000, 32'h1300, 4, 0, 0, 6, 25);
        checkOutput("abort_no_done", done_cyc, 0);
        checkOutput("abort_remaining", {20'h0, remaining}, 32'h2);
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_reads", rd_count - rd_base, 2);
        checkOutput("abort_d1", mem[12'h4C1], 32'h0000_0022);
        checkOutput("abort_d2_untouched", mem[12'h4C2], 32'h0);

        $display("[TB] destination pointer wrap");
        applyStimulus(32'h1000, 32'hFFFF_FFFC, 2, 0, 0, 0, 30);
        checkOutput("wrap_done_cycle", done_cyc, 8);
        checkOutput("wrap_d0", mem[12'hFFF], 32'h0000_0011);
        checkOutput("wrap_d1", mem[12'h000], 32'h0000_0022);
        checkOutput("wrap_last_addr", last_wr_addr, 32'h0);

`ifdef DMA_FILL_EN
        $display("[TB] fill mode");
        fill_mode  = 1'b1;
        fill_value = 32'hDEAD_BEEF;
        applyStimulus(32'h1000, 32'h1400, 3, 0, 0, 0, 20);
        fill_mode  = 1'b0;
        checkOutput("fill_done_cycle", done_cyc, 5);
        checkOutput("fill_reads", rd_count - rd_base, 0);
        checkOutput("fill_writes", wr_count - wr_base, 3);
        checkOutput("fill_d0", mem[12'h500], 32'hDEAD_BEEF);
        checkOutput("fill_d2", mem[12'h502], 32'hDEAD_BEEF);
`endif

        $display("[TB] reset mid-transfer");
        @(negedge clk);
        src_addr  = 32'h1000;
        dst_addr  = 32'h1500;
        len_words = LEN_W'(4);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
        checkOutput("midrst_memwrite", {31'h0, memwrite}, 32'h0);
        checkOutput("midrst_remaining", {20'h0, remaining}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("sign_mask_monitor", bad_mask, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
